// File: rtl/dm_responder.sv
// Data-memory responder for the M-stage data port: combinational reads, byte-lane stores.
// Committed stores are recorded in a drainable write log. DM_LOG_DISPLAY_EN enables a store trace printout.
module dm_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LOG_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        err_addr,
  output logic [31:0] err_addr_value,
  output logic [31:0] wr_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   widx;
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          wr;
  logic          bad;

  assign widx     = (m_data_addr - BASE_ADDR) >> 2;
  assign in_range = (m_data_addr >= BASE_ADDR) && (widx < 32'(DEPTH_WORDS));
  assign idx      = widx[AW-1:0];
  assign old_word = in_range ? mem[idx] : 32'h0;
  assign wr       = (m_data_byteen != 4'b0000) && in_range;
  assign bad      = (m_data_byteen != 4'b0000) && !in_range;

  // Reads see the pre-store word; the store lands at the edge.
  assign m_data_rdata = old_word;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_mem
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem[g] <= 32'h0;
      end else if (wr && (idx == AW'(g))) begin
        mem[g] <= merged;
      end
    end
  end

  // Write log: circular buffer, head always presented on log_*.
  logic [31:0] fifo_pc   [LOG_DEPTH];
  logic [31:0] fifo_addr [LOG_DEPTH];
  logic [31:0] fifo_data [LOG_DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW:0]   cnt;
  logic          full;
  logic          pop;
  logic          push;

  assign full      = (cnt == (LW+1)'(LOG_DEPTH));
  assign log_valid = (cnt != '0);
  assign pop       = log_valid && log_ready;
  // A full log still accepts a record when the head leaves in the same cycle.
  assign push      = wr && (!full || pop);

  assign log_pc   = log_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign log_addr = log_valid ? fifo_addr[rd_ptr] : 32'h0;
  assign log_data = log_valid ? fifo_data[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= m_inst_addr;
      fifo_addr[wr_ptr] <= {m_data_addr[31:2], 2'b00};
      fifo_data[wr_ptr] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr && !push) log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_addr       <= 1'b0;
      err_addr_value <= 32'h0;
      wr_count       <= 32'h0;
    end else begin
      if (bad) begin
        err_addr <= 1'b1;
        if (!err_addr) err_addr_value <= m_data_addr;
      end
      if (wr && (wr_count != 32'hFFFF_FFFF)) wr_count <= wr_count + 32'd1;
    end
  end

`ifdef DM_LOG_DISPLAY_EN
  always @(posedge clk) begin
    if (reset) begin
      if (wr)
        $display("%d@%h: *%h <= %h", $time, m_inst_addr, {m_data_addr[31:2], 2'b00}, merged);
      else if (bad)
        $display("DM ERR @%h: %h", m_inst_addr, m_data_addr);
    end
  end
`else
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: queue/array reference model checked every cycle, plus directed literal checks.
module tb_dm_responder;
  localparam int LOG_DEPTH = 8;
  localparam int DEPTH     = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_data_addr = '0, m_data_wdata = '0, m_inst_addr = '0;
  logic [3:0]  m_data_byteen = '0;
  logic        log_ready = 1'b0;
  logic [31:0] m_data_rdata, log_pc, log_addr, log_data, err_addr_value, wr_count;
  logic        log_valid, log_overflow, err_addr;

  dm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data),
    .log_overflow(log_overflow), .err_addr(err_addr), .err_addr_value(err_addr_value),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sparse word memory, a queue for the log, plain flags/counters.
  typedef struct { logic [31:0] pc; logic [31:0] addr; logic [31:0] data; } ent_t;
  logic [31:0] mmem [int unsigned];
  ent_t        mq [$];
  logic        movf, merr;
  logic [31:0] mval;
  longint      mcount;

  function automatic bit m_in_range(input logic [31:0] a);
    return (a / 4) < DEPTH;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_in_range(a)) return 32'h0;
    if (mmem.exists(a / 4)) return mmem[a / 4];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmem.delete(); mq.delete();
      movf = 0; merr = 0; mval = 0; mcount = 0;
    end else begin
      logic [31:0] w;
      ent_t e;
      if (mq.size() != 0 && log_ready) void'(mq.pop_front());
      if (m_data_byteen != 0) begin
        if (m_in_range(m_data_addr)) begin
          w = m_read(m_data_addr);
          for (int i = 0; i < 4; i++)
            if (m_data_byteen[i]) w[8*i +: 8] = m_data_wdata[8*i +: 8];
          mmem[m_data_addr / 4] = w;
          if (mcount < 64'hFFFF_FFFF) mcount++;
          e.pc = m_inst_addr; e.addr = m_data_addr & ~32'h3; e.data = w;
          if (mq.size() < LOG_DEPTH) mq.push_back(e);
          else movf = 1;
        end else begin
          if (!merr) mval = m_data_addr;
          merr = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rdata", m_data_rdata, m_read(m_data_addr));
      chk("log_valid", {31'b0, log_valid}, {31'b0, mq.size() != 0});
      chk("log_pc",   log_pc,   mq.size() != 0 ? mq[0].pc   : 32'h0);
      chk("log_addr", log_addr, mq.size() != 0 ? mq[0].addr : 32'h0);
      chk("log_data", log_data, mq.size() != 0 ? mq[0].data : 32'h0);
      chk("log_overflow", {31'b0, log_overflow}, {31'b0, movf});
      chk("err_addr", {31'b0, err_addr}, {31'b0, merr});
      chk("err_addr_value", err_addr_value, mval);
      chk("wr_count", wr_count, mcount[31:0]);
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc, input logic rdy);
    @(posedge clk); #1;
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc; log_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(32'h0, 32'h0, 4'b0000, 32'h0, rdy);
  endtask

  task automatic reset_pulse();
    idle(1'b0);
    #3 reset = 1'b0;
    @(posedge clk); #3 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // Reset state
    drive(32'h10, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("reset rdata", m_data_rdata, 32'h0);
    chk("reset log_valid", {31'b0, log_valid}, 32'h0);
    chk("reset wr_count", wr_count, 32'h0);

    // Full-word store then single-lane merge
    drive(32'h8, 32'h1234_5678, 4'b1111, 32'h3000, 1'b0);
    drive(32'hA, 32'h0000_AB00, 4'b0010, 32'h3004, 1'b0);
    @(negedge clk);
    chk("merge pre-store rdata", m_data_rdata, 32'h1234_5678);
    chk("log1 pc", log_pc, 32'h3000);
    chk("log1 addr", log_addr, 32'h8);
    chk("log1 data", log_data, 32'h1234_5678);
    drive(32'h8, 32'h0, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("merged rdata", m_data_rdata, 32'h1234_AB78);
    drive(32'h8, 32'h0, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("log2 pc", log_pc, 32'h3004);
    chk("log2 addr", log_addr, 32'h8);
    chk("log2 data", log_data, 32'h1234_AB78);
    idle(1'b1);
    @(negedge clk);
    chk("log drained", {31'b0, log_valid}, 32'h0);

    // Same-cycle store and read
    drive(32'h4, 32'hDEAD_BEEF, 4'b1111, 32'h3010, 1'b1);
    @(negedge clk);
    chk("same-cycle rdata", m_data_rdata, 32'h0);
    drive(32'h4, 32'h0, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("next-cycle rdata", m_data_rdata, 32'hDEAD_BEEF);

    // Overflow: nine stores into an eight-entry log
    reset_pulse();
    for (int k = 0; k < 9; k++)
      drive(32'h100 + 4*k, 32'hA000_0000 + k, 4'b1111, 32'h4000 + 4*k, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("ovf log_overflow", {31'b0, log_overflow}, 32'h1);
    chk("ovf wr_count", wr_count, 32'd9);
    chk("ovf rdata9", m_data_rdata, 32'h0);
    for (int k = 0; k < 8; k++) begin
      drive(32'h100 + 4*8, 32'h0, 4'b0000, 32'h0, 1'b1);
      @(negedge clk);
      chk("drain pc", log_pc, 32'h4000 + 4*k);
      chk("drain data", log_data, 32'hA000_0000 + k);
    end
    idle(1'b1);
    @(negedge clk);
    chk("drain empty", {31'b0, log_valid}, 32'h0);

    // Out-of-range stores
    drive(32'h0000_4000, 32'h1111_1111, 4'b1111, 32'h5000, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("oor err_addr", {31'b0, err_addr}, 32'h1);
    chk("oor err_value", err_addr_value, 32'h4000);
    chk("oor no push", {31'b0, log_valid}, 32'h0);
    chk("oor wr_count", wr_count, 32'd9);
    drive(32'h0000_5000, 32'h2222_2222, 4'b0001, 32'h5004, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("oor2 err_value", err_addr_value, 32'h4000);

    // Mixed traffic with random ready; pushes coincide with pops on a full log
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'h0000_4000 + a;
      drive(a, $urandom, 4'($urandom_range(0, 15)), 32'h6000 + 4*k, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset with pending log entries
    reset_pulse();
    drive(32'h20, 32'hCAFE_0001, 4'b1111, 32'h7000, 1'b0);
    drive(32'h24, 32'hCAFE_0002, 4'b1111, 32'h7004, 1'b0);
    drive(32'h28, 32'hCAFE_0003, 4'b1111, 32'h7008, 1'b0);
    drive(32'h20, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("pre-reset log_valid", {31'b0, log_valid}, 32'h1);
    chk("pre-reset rdata", m_data_rdata, 32'hCAFE_0001);
    #2 reset = 1'b0;
    #1;
    chk("async log_valid", {31'b0, log_valid}, 32'h0);
    chk("async rdata", m_data_rdata, 32'h0);
    chk("async wr_count", wr_count, 32'h0);
    @(posedge clk); #3 reset = 1'b1;
    drive(32'h24, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("post-reset rdata", m_data_rdata, 32'h0);
    idle(1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
